// File: rtl/alu_sweep_ctrl.sv
// Drives every ALU opcode for one latched operand pair, streams each result
// over valid/ready and folds it into a rotate-XOR signature.
module alu_sweep_ctrl #(
    parameter int unsigned DW      = 4,
    parameter int unsigned OPW     = 4,
    parameter int unsigned YW      = 5,
    parameter int unsigned NUM_OPS = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [DW-1:0]  a_in,
    input  logic [DW-1:0]  b_in,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [YW-1:0]  alu_y,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [OPW-1:0] res_op,
    output logic [YW-1:0]  res_y,
    output logic [15:0]    sig,
    output logic           busy,
    output logic           done
);

    localparam int unsigned SIGW = 16;
    localparam logic [OPW-1:0] LAST_OP = OPW'(NUM_OPS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        CAPTURE = 3'd2,
        EMIT    = 3'd3,
        FIN     = 3'd4
    } state_t;

    state_t state;

    // Sequencer: every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_op    <= '0;
            res_y     <= '0;
            sig       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        alu_a  <= a_in;
                        alu_b  <= b_in;
                        alu_op <= '0;
                        sig    <= '0;
                        busy   <= 1'b1;
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    res_y     <= alu_y;
                    res_op    <= alu_op;
                    sig       <= {sig[SIGW-2:0], sig[SIGW-1]} ^ SIGW'(alu_y);
                    res_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    // Stall here until the beat is taken; nothing else moves.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (alu_op == LAST_OP) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            alu_op <= alu_op + OPW'(1);
                            state  <= DRIVE;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Bench for alu_sweep_ctrl: stub ALU y = {0,a} + op, directed and random sweeps
// checked against a queue-free arithmetic model of beats, timing and signature.
module tb_alu_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, res_ready;
    logic [3:0] a_in, b_in, alu_a, alu_b, alu_op, res_op;
    logic [4:0] alu_y, res_y;
    logic [15:0] sig;
    logic       res_valid, busy, done;

    logic       start1, res_ready1;
    logic [3:0] a_in1, b_in1, alu_a1, alu_b1, alu_op1, res_op1;
    logic [4:0] alu_y1, res_y1;
    logic [15:0] sig1;
    logic       res_valid1, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign alu_y  = {1'b0, alu_a}  + 5'(alu_op);
    assign alu_y1 = {1'b0, alu_a1} + 5'(alu_op1);

    alu_sweep_ctrl #(.DW(4), .OPW(4), .YW(5), .NUM_OPS(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_op(res_op),
        .res_y(res_y), .sig(sig), .busy(busy), .done(done)
    );

    alu_sweep_ctrl #(.DW(4), .OPW(4), .YW(5), .NUM_OPS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a_in1), .b_in(b_in1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_y(alu_y1),
        .res_valid(res_valid1), .res_ready(res_ready1), .res_op(res_op1),
        .res_y(res_y1), .sig(sig1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Signature of a full sweep: rotate left by one, XOR in a+op.
    function automatic logic [15:0] model_sig(input int a, input int nops);
        int unsigned s;
        s = 0;
        for (int op = 0; op < nops; op++)
            s = (((s << 1) | (s >> 15)) & 32'hFFFF) ^ 32'(a + op);
        return 16'(s);
    endfunction

    task automatic run_sweep(input logic [3:0] a, input logic [3:0] b, input int stall_op,
                             input int stall_len, input bit rand_ready, input int restart_op);
        int  exp_op, cycle, stalls, stalled, beats;
        bit  finished, restarted;
        @(negedge clk);
        a_in = a; b_in = b; start = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycle = 1; exp_op = 0; stalls = 0; stalled = 0; beats = 0;
        finished = 1'b0; restarted = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        check("sig_clear", 32'(sig), 32'd0);
        check("op_start", 32'(alu_op), 32'd0);
        while (!finished && cycle < 300) begin
            start = 1'b0;
            check("alu_a_hold", 32'(alu_a), 32'(a));
            check("alu_b_hold", 32'(alu_b), 32'(b));
            if (done) begin
                finished = 1'b1;
                check("done_cycle", 32'(cycle), 32'(37 + stalls));
                check("beat_count", 32'(beats), 32'd12);
                check("sig_final", 32'(sig), 32'(model_sig(int'(a), 12)));
                check("busy_fin", 32'(busy), 32'd1);
                check("op_final", 32'(alu_op), 32'd11);
            end else begin
                check("busy_mid", 32'(busy), 32'd1);
                if (res_valid) begin
                    check("res_op", 32'(res_op), 32'(exp_op));
                    check("res_y", 32'(res_y), 32'((int'(a) + exp_op) & 31));
                    check("alu_op_emit", 32'(alu_op), 32'(exp_op));
                    if (exp_op == restart_op && !restarted) begin
                        start = 1'b1; a_in = ~a; b_in = ~b; restarted = 1'b1;
                    end
                    if (exp_op == stall_op && stalled < stall_len) begin
                        res_ready = 1'b0; stalled++;
                    end else if (rand_ready) begin
                        res_ready = 1'($urandom_range(0, 1));
                    end else begin
                        res_ready = 1'b1;
                    end
                    if (res_ready) begin
                        beats++; exp_op++;
                    end else begin
                        stalls++;
                    end
                end else begin
                    res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
            @(negedge clk);
            cycle++;
        end
        if (!finished) check("sweep_timeout", 32'd0, 32'd1);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_fall", 32'(busy), 32'd0);
        check("valid_idle", 32'(res_valid), 32'd0);
        check("sig_hold", 32'(sig), 32'(model_sig(int'(a), 12)));
        res_ready = 1'b1;
    endtask

    initial begin
        int  cyc, beats1;
        bit  seen;
        logic [3:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; res_ready = 1'b1; a_in = '0; b_in = '0;
        start1 = 1'b0; res_ready1 = 1'b1; a_in1 = '0; b_in1 = '0;
        #1;
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sig", 32'(sig), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_res_y", 32'(res_y), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Directed sweeps, backpressure on op 3, restart ignored at op 6.
        run_sweep(4'b1110, 4'b1001, -1, 0, 1'b0, -1);
        run_sweep(4'b0101, 4'b1000, -1, 0, 1'b0, -1);
        run_sweep(4'b0011, 4'b0110, 3, 5, 1'b0, -1);
        run_sweep(4'b1010, 4'b0001, -1, 0, 1'b0, 6);

        // Asynchronous reset between edges during the op-4 beat.
        @(negedge clk);
        a_in = 4'd7; b_in = 4'd2; start = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (res_valid && res_op == 4'd4) seen = 1'b1;
            else @(negedge clk);
        end
        check("reach_op4", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(res_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_alu_op", 32'(alu_op), 32'd0);
        check("arst_sig", 32'(sig), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        run_sweep(4'd7, 4'd2, -1, 0, 1'b0, -1);

        // Random operands with random backpressure.
        for (int k = 0; k < 3; k++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run_sweep(ra, rb, -1, 0, 1'b1, -1);
        end

        // Single-opcode build.
        ra = 4'($urandom_range(0, 15));
        @(negedge clk);
        a_in1 = ra; b_in1 = 4'd3; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 1; beats1 = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            if (done1) begin
                seen = 1'b1;
                check("n1_done_cycle", 32'(cyc), 32'd4);
                check("n1_beats", 32'(beats1), 32'd1);
                check("n1_sig", 32'(sig1), 32'(model_sig(int'(ra), 1)));
            end else if (res_valid1) begin
                check("n1_res_op", 32'(res_op1), 32'd0);
                check("n1_res_y", 32'(res_y1), 32'(ra));
                beats1++;
            end
            @(negedge clk);
            cyc++;
        end
        if (!seen) check("n1_timeout", 32'd0, 32'd1);
        check("n1_busy_fall", 32'(busy1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
